// File: rtl/matmul_c_writeback_arbiter_if.sv
// Bus bundle between the two C-output tile streams and the C-matrix RAM write port.
// Handshake: valid-only, no ready. A word transfers on every cycle its valid/we is high;
// the receiver must take it or account for the loss (the arbiter flags drops as overflow).
interface matmul_c_writeback_arbiter_if #(
    parameter int DWIDTH          = 8,
    parameter int BB_MAT_MUL_SIZE = 16,
    parameter int AWIDTH          = 10
);
    localparam int W = BB_MAT_MUL_SIZE * DWIDTH;

    logic [W-1:0]      c_data_0;
    logic [AWIDTH-1:0] c_addr_0;
    logic              c_valid_0;
    logic [W-1:0]      c_data_1;
    logic [AWIDTH-1:0] c_addr_1;
    logic              c_valid_1;

    logic              ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [W-1:0]      ram_wdata;

    modport master (
        output c_data_0, c_addr_0, c_valid_0,
        output c_data_1, c_addr_1, c_valid_1,
        input  ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  c_data_0, c_addr_0, c_valid_0,
        input  c_data_1, c_addr_1, c_valid_1,
        output ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/matmul_c_writeback_arbiter.sv
// Writeback stage: buffers two C-word streams in per-channel FIFOs and round-robins
// them onto one RAM write port, counting writes against a programmed total.
module matmul_c_writeback_arbiter #(
    parameter int DWIDTH          = 8,
    parameter int BB_MAT_MUL_SIZE = 16,
    parameter int AWIDTH          = 10,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_words,
    matmul_c_writeback_arbiter_if.slave bus,
    output logic                 done,
    output logic                 busy,
    output logic [1:0]           overflow,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic [1:0]           dbg_state_o
);
    localparam int W  = BB_MAT_MUL_SIZE * DWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AWIDTH + W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0] words_written_q;
    logic                 ptr_q;
    logic [1:0]           overflow_q;
    logic                 ram_we_q;
    logic [AWIDTH-1:0]    ram_addr_q;
    logic [W-1:0]         ram_wdata_q;

    logic [EW-1:0] mem_q    [2][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW:0]   cnt_q    [2];

    logic [EW-1:0] wr_entry [2];
    logic [EW-1:0] head     [2];
    logic [1:0]    push;
    logic [1:0]    nonempty;
    logic [1:0]    full;
    logic [1:0]    pop;
    logic [1:0]    accept;
    logic [1:0]    drop;
    logic          grant;
    logic          pop_any;
    logic          can_write;

    always_comb begin
        wr_entry[0] = {bus.c_addr_0, bus.c_data_0};
        wr_entry[1] = {bus.c_addr_1, bus.c_data_1};
        push        = {bus.c_valid_1, bus.c_valid_0};
        for (int k = 0; k < 2; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
            full[k]     = (cnt_q[k] == (PW+1)'(FIFO_DEPTH));
            head[k]     = mem_q[k][rd_ptr_q[k]];
        end

        // Stop granting once the issued count reaches the target so no extra word leaves its FIFO.
        can_write = (state_q == S_RUN) && (words_written_q != target_q);
        pop       = 2'b00;
        grant     = 1'b0;
        if (can_write) begin
            if (nonempty[0] && nonempty[1]) begin
                grant      = ptr_q;
                pop[ptr_q] = 1'b1;
            end else if (nonempty[0]) begin
                grant  = 1'b0;
                pop[0] = 1'b1;
            end else if (nonempty[1]) begin
                grant  = 1'b1;
                pop[1] = 1'b1;
            end
        end
        pop_any = |pop;

        for (int k = 0; k < 2; k++) begin
            accept[k] = push[k] && (!full[k] || pop[k]);
            drop[k]   = push[k] && full[k] && !pop[k];
        end
    end

    // Capture runs in every state; only reset clears the FIFOs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (accept[k]) begin
                    mem_q[k][wr_ptr_q[k]] <= wr_entry[k];
                    wr_ptr_q[k]           <= wr_ptr_q[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                end
                cnt_q[k] <= cnt_q[k] + (PW+1)'(accept[k]) - (PW+1)'(pop[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            target_q        <= '0;
            words_written_q <= '0;
            ptr_q           <= 1'b0;
            overflow_q      <= 2'b00;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
        end else begin
            ram_we_q   <= pop_any;
            overflow_q <= overflow_q | drop;
            if (pop_any) begin
                ram_addr_q      <= head[grant][EW-1:W];
                ram_wdata_q     <= head[grant][W-1:0];
                words_written_q <= words_written_q + CNT_WIDTH'(1);
                ptr_q           <= ~grant;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q         <= S_RUN;
                        target_q        <= num_words;
                        words_written_q <= '0;
                        overflow_q      <= drop;
                        ptr_q           <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Reached only once the final write is on the bus (or at once for a zero target).
                    if (words_written_q == target_q) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign done          = (state_q == S_DONE);
    assign busy          = (state_q == S_RUN);
    assign overflow      = overflow_q;
    assign words_written = words_written_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_matmul_c_writeback_arbiter.sv
// Directed + randomized bench for matmul_c_writeback_arbiter against a queue-based reference model.
module tb_matmul_c_writeback_arbiter;
    localparam int DW = 8;
    localparam int BB = 16;
    localparam int AW = 10;
    localparam int CW = 16;
    localparam int W  = BB * DW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_words;
    logic          done;
    logic          busy;
    logic [1:0]    overflow;
    logic [CW-1:0] words_written;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    matmul_c_writeback_arbiter_if #(.DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW)) bus ();

    matmul_c_writeback_arbiter #(
        .DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_words     (num_words),
        .bus           (bus.slave),
        .done          (done),
        .busy          (busy),
        .overflow      (overflow),
        .words_written (words_written),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel word queues plus run bookkeeping.
    logic [AW+W-1:0] q0[$];
    logic [AW+W-1:0] q1[$];
    int              m_mode;   // 0 idle, 1 run, 2 done
    int              m_tgt;
    int              m_ww;
    int              m_next;   // channel favoured when both queues hold words
    logic [1:0]      m_ovf;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [W-1:0]    m_data;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic [CW-1:0] nw,
                        input logic v0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
        logic [AW+W-1:0] e;
        logic p0, p1;
        reset         = r;
        start         = st;
        num_words     = nw;
        bus.c_valid_0 = v0;
        bus.c_addr_0  = a0;
        bus.c_data_0  = d0;
        bus.c_valid_1 = v1;
        bus.c_addr_1  = a1;
        bus.c_data_1  = d1;
        e  = '0;
        p0 = 1'b0;
        p1 = 1'b0;
        if (r) begin
            q0.delete();
            q1.delete();
            m_mode = 0; m_tgt = 0; m_ww = 0; m_next = 0;
            m_ovf = 2'b00; m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (m_mode == 1 && m_ww != m_tgt) begin
                if (q0.size() > 0 && q1.size() > 0) begin
                    if (m_next == 0) p0 = 1'b1; else p1 = 1'b1;
                end else if (q0.size() > 0) p0 = 1'b1;
                else if (q1.size() > 0) p1 = 1'b1;
            end
            m_we = p0 | p1;
            if (p0) begin e = q0.pop_front(); m_next = 1; end
            if (p1) begin e = q1.pop_front(); m_next = 0; end
            if (m_we) begin
                m_addr = e[AW+W-1:W];
                m_data = e[W-1:0];
            end
            if (m_mode != 1 && st) begin
                m_mode = 1; m_tgt = int'(nw); m_ww = 0; m_ovf = 2'b00; m_next = 0;
            end else if (m_mode == 1 && m_ww == m_tgt) begin
                m_mode = 2;
            end
            if (m_we) m_ww++;
            if (v0) begin
                if (q0.size() < DEPTH) q0.push_back({a0, d0}); else m_ovf[0] = 1'b1;
            end
            if (v1) begin
                if (q1.size() < DEPTH) q1.push_back({a1, d1}); else m_ovf[1] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("ram_we",        160'(bus.ram_we),    160'(m_we));
        chk("ram_addr",      160'(bus.ram_addr),  160'(m_addr));
        chk("ram_wdata",     160'(bus.ram_wdata), 160'(m_data));
        chk("busy",          160'(busy),          160'(m_mode == 1));
        chk("done",          160'(done),          160'(m_mode == 2));
        chk("overflow",      160'(overflow),      160'(m_ovf));
        chk("words_written", 160'(words_written), 160'(m_ww));
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic go(input logic [CW-1:0] nw);
        step(1'b0, 1'b1, nw, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_words = '0;
        bus.c_valid_0 = 1'b0; bus.c_addr_0 = '0; bus.c_data_0 = '0;
        bus.c_valid_1 = 1'b0; bus.c_addr_1 = '0; bus.c_data_1 = '0;

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);

        // 1: single channel, four words
        go(16'd4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'hA0 + 8'(i);
            step(1'b0, 1'b0, '0, 1'b1, AW'(10'h10 + i), {16{b}}, 1'b0, '0, '0);
        end
        idle(3);
        chk("t1_done", 160'(done), 160'(1));
        chk("t1_busy", 160'(busy), 160'(0));
        chk("t1_ww",   160'(words_written), 160'(4));

        // 2: simultaneous streams alternate
        go(16'd8);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, '0, 1'b1, AW'(i), rnd_word(), 1'b1, AW'(10'h40 + i), rnd_word());
        idle(8);
        chk("t2_done", 160'(done), 160'(1));

        // 3: overflow in idle, then drain the sixteen kept words
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, AW'(10'h100 + i), rnd_word());
        chk("t3_ovf_set", 160'(overflow), 160'(2'b10));
        go(16'd16);
        chk("t3_ovf_clr", 160'(overflow), 160'(2'b00));
        idle(20);
        chk("t3_done", 160'(done), 160'(1));

        // 4: full FIFO pushed while popping
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, '0, 1'b1, AW'(10'h200 + i), rnd_word(), 1'b0, '0, '0);
        go(16'd24);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, '0, 1'b1, AW'(10'h210 + i), rnd_word(), 1'b0, '0, '0);
        idle(20);
        chk("t4_ovf",  160'(overflow), 160'(2'b00));
        chk("t4_done", 160'(done), 160'(1));

        // 5: zero target, restart from DONE, start ignored in RUN
        go(16'd0);
        idle(1);
        chk("t5_zero_done", 160'(done), 160'(1));
        go(16'd2);
        chk("t5_busy", 160'(busy), 160'(1));
        chk("t5_ww0",  160'(words_written), 160'(0));
        go(16'd7);
        step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, AW'(10'h300), rnd_word());
        step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, AW'(10'h301), rnd_word());
        idle(4);
        chk("t5_ww2", 160'(words_written), 160'(2));

        // 6: reset after three writes
        go(16'd8);
        for (int i = 0; i < 12; i++) begin
            if (m_ww == 3) break;
            if (i < 4) step(1'b0, 1'b0, '0, 1'b1, AW'(i), rnd_word(), 1'b1, AW'(10'h40 + i), rnd_word());
            else idle(1);
        end
        chk("t6_pre_ww", 160'(words_written), 160'(3));
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("t6_we",   160'(bus.ram_we), 160'(0));
        chk("t6_busy", 160'(busy), 160'(0));
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'b0, ($urandom_range(0, 99) < 6), CW'($urandom_range(0, 12)),
                 ($urandom_range(0, 99) < 45), AW'($urandom_range(0, 1023)), rnd_word(),
                 ($urandom_range(0, 99) < 45), AW'($urandom_range(0, 1023)), rnd_word());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
